uart_score_reporter: RTL



---
 rtl/uart_score_reporter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_score_reporter.sv
// Formats game events (start, score change, game over) into 8-byte ASCII frames
// "T:ddddd<EOL>" and writes them byte by byte into the UART TX FIFO.
module uart_score_reporter #(
  parameter bit         SCORE_EN = 1'b1,
  parameter logic [7:0] EOL_CHAR = 8'h0A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score_in,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        tx_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  output logic        busy,
  output logic [7:0]  frames_sent
);

  typedef enum logic [1:0] {IDLE, CONV, PUT, GAP} state_e;

  localparam logic [7:0] TAG_G = 8'h47;
  localparam logic [7:0] TAG_S = 8'h53;
  localparam logic [7:0] TAG_P = 8'h50;

  state_e      state_q, state_d;
  logic        prev_start_q, prev_over_q;
  logic [15:0] last_score_q;
  logic        pend_g_q, pend_g_d, pend_s_q, pend_s_d, pend_p_q, pend_p_d;
  logic [7:0]  tag_q, tag_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d, bcd_adj;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  frames_q, frames_d;
  logic [7:0]  frame_byte;
  logic        any_pend, take;
  logic        clr_g, clr_s, clr_p;

  assign any_pend = pend_g_q | pend_s_q | pend_p_q;
  assign take     = (state_q == IDLE) && any_pend;
  assign clr_g    = take & pend_g_q;
  assign clr_s    = take & ~pend_g_q & pend_s_q;
  assign clr_p    = take & ~pend_g_q & ~pend_s_q & pend_p_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the values computed before the edge regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_start_q <= 1'b0;
      prev_over_q  <= 1'b0;
      last_score_q <= '0;
      pend_g_q     <= 1'b0;
      pend_s_q     <= 1'b0;
      pend_p_q     <= 1'b0;
      tag_q        <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      frames_q     <= '0;
    end else begin
      state_q      <= state_d;
      prev_start_q <= game_start;
      prev_over_q  <= game_over;
      last_score_q <= score_in;
      pend_g_q     <= pend_g_d;
      pend_s_q     <= pend_s_d;
      pend_p_q     <= pend_p_d;
      tag_q        <= tag_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frames_q     <= frames_d;
    end
  end

  // A new event in the same cycle as its flag is consumed wins, so it is never lost.
  always_comb begin
    pend_g_d = (pend_g_q & ~clr_g) | (game_over & ~prev_over_q);
    pend_s_d = (pend_s_q & ~clr_s) | (game_start & ~prev_start_q);
    pend_p_d = (pend_p_q & ~clr_p) |
               (SCORE_EN && game_start && !game_over && (score_in != last_score_q));
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    bcd_adj  = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    tag_d    = tag_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    frames_d = frames_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (any_pend) begin
          bin_d = score_in;
          bcd_d = '0;
          tag_d = pend_g_q ? TAG_G : (pend_s_q ? TAG_S : TAG_P);
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj[18:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
      end
      GAP: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) frames_d = frames_q + 8'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pend) state_d = CONV;
      CONV:    if (cnt_q == 4'd15) state_d = PUT;
      PUT:     if (!tx_full) state_d = GAP;
      GAP:     state_d = (idx_q == 3'd7) ? IDLE : PUT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (idx_q)
      3'd0:    frame_byte = tag_q;
      3'd1:    frame_byte = 8'h3A;
      3'd2:    frame_byte = 8'h30 + {4'h0, bcd_q[19:16]};
      3'd3:    frame_byte = 8'h30 + {4'h0, bcd_q[15:12]};
      3'd4:    frame_byte = 8'h30 + {4'h0, bcd_q[11:8]};
      3'd5:    frame_byte = 8'h30 + {4'h0, bcd_q[7:4]};
      3'd6:    frame_byte = 8'h30 + {4'h0, bcd_q[3:0]};
      default: frame_byte = EOL_CHAR;
    endcase
    busy        = (state_q != IDLE);
    // Gating with rst keeps a mid-frame reset from leaking one more write.
    wr_uart     = (state_q == PUT) && !tx_full && !rst;
    w_data      = (state_q == PUT) ? frame_byte : 8'h00;
    frames_sent = frames_q;
  end

endmodule
